// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolver with a one-deep result register and a
// PC-indexed table of 2-bit saturating counters used to flag mispredicts.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_pred,
  output logic             out_mispredict,
  output logic             out_link,
  output logic             out_illegal
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [4:0] OP_JUMP   = 5'b00011;
  localparam logic [4:0] OP_BRANCH = 5'b00100;

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic             accept;
  logic             op_zero;
  logic             op_neg;
  logic             is_jump;
  logic             is_branch;
  logic             legal;
  logic             taken_c;
  logic             link_c;
  logic             pred_c;

  // Upper pc bits only alias counters; they carry no other meaning here.
  generate
    if (IDX_W < PC_W) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^in_pc[PC_W-1:IDX_W];
    end
  endgenerate

  assign idx      = in_pc[IDX_W-1:0];
  assign ctr_cur  = ctr[idx];
  assign in_ready = !reset && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign op_zero  = ~|in_operand;
  assign op_neg   = in_operand[WIDTH-1];

  always_comb begin
    is_jump   = 1'b0;
    is_branch = 1'b0;
    taken_c   = 1'b0;
    link_c    = 1'b0;
    if (in_opcode == OP_JUMP) begin
      case (in_func)
        4'b0000: begin is_jump = 1'b1; taken_c = 1'b1; end
        4'b0001: begin is_jump = 1'b1; taken_c = 1'b1; link_c = 1'b1; end
        default: ;
      endcase
    end else if (in_opcode == OP_BRANCH) begin
      case (in_func)
        4'b0000: begin is_branch = 1'b1; taken_c = op_zero; end
        4'b0010: begin is_branch = 1'b1; taken_c = !op_neg && !op_zero; end
        4'b0001: begin is_branch = 1'b1; taken_c = op_neg; end
        default: ;
      endcase
    end
    legal  = is_jump || is_branch;
    pred_c = is_jump || (is_branch && ctr_cur[1]);

    ctr_nxt = ctr_cur;
    if (taken_c) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else if (ctr_cur != 2'b00) begin
      ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_pred       <= 1'b0;
      out_mispredict <= 1'b0;
      out_link       <= 1'b0;
      out_illegal    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= taken_c;
      out_pred       <= pred_c;
      out_mispredict <= legal && (taken_c != pred_c);
      out_link       <= link_c;
      out_illegal    <= !legal;
      if (is_branch) ctr[idx] <= ctr_nxt;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed sequences, a vector table and a
// randomized phase, all checked against a counter-table reference model.
module tb_branch_resolve_unit;
  localparam int WIDTH = 32;
  localparam int PC_W  = 16;
  localparam int DEPTH = 16;
  localparam logic [4:0] OP_JUMP   = 5'b00011;
  localparam logic [4:0] OP_BRANCH = 5'b00100;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush;
  logic [4:0]       in_opcode;
  logic [3:0]       in_func;
  logic [WIDTH-1:0] in_operand;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid, out_ready, out_taken, out_pred;
  logic             out_mispredict, out_link, out_illegal;

  int checks = 0;
  int errors = 0;
  int mctr [DEPTH];

  typedef struct packed {
    logic taken;
    logic link;
    logic illegal;
    logic pred;
    logic mis;
  } res_t;

  typedef struct packed {
    logic [4:0]       op;
    logic [3:0]       fn;
    logic [WIDTH-1:0] opnd;
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic             link;
    logic             illegal;
  } vec_t;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func), .in_operand(in_operand),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_pred(out_pred), .out_mispredict(out_mispredict),
    .out_link(out_link), .out_illegal(out_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode from the rule list, counters as plain integers 0..3.
  task automatic model_req(input logic [4:0] op, input logic [3:0] fn,
                           input logic [WIDTH-1:0] opnd, input logic [PC_W-1:0] pc,
                           output res_t r);
    int s;
    int idx;
    s   = $signed(opnd);
    idx = int'(pc) % DEPTH;
    r   = '0;
    if (op == OP_JUMP && (fn == 4'd0 || fn == 4'd1)) begin
      r.taken = 1'b1;
      r.link  = (fn == 4'd1);
      r.pred  = 1'b1;
    end else if (op == OP_BRANCH && (fn == 4'd0 || fn == 4'd1 || fn == 4'd2)) begin
      if (fn == 4'd0)      r.taken = (s == 0);
      else if (fn == 4'd1) r.taken = (s < 0);
      else                 r.taken = (s > 0);
      r.pred = (mctr[idx] >= 2);
      if (r.taken) mctr[idx] = (mctr[idx] == 3) ? 3 : mctr[idx] + 1;
      else         mctr[idx] = (mctr[idx] == 0) ? 0 : mctr[idx] - 1;
    end else begin
      r.illegal = 1'b1;
    end
    r.mis = !r.illegal && (r.taken != r.pred);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mctr[i] = 1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] fn,
                       input logic [WIDTH-1:0] opnd, input logic [PC_W-1:0] pc);
    in_valid   = v;
    in_opcode  = op;
    in_func    = fn;
    in_operand = opnd;
    in_pc      = pc;
  endtask

  task automatic check_fields(input string name, input res_t e);
    check({name, ".taken"},      out_taken,      e.taken);
    check({name, ".pred"},       out_pred,       e.pred);
    check({name, ".mispredict"}, out_mispredict, e.mis);
    check({name, ".link"},       out_link,       e.link);
    check({name, ".illegal"},    out_illegal,    e.illegal);
  endtask

  task automatic check_out(input string name, input res_t e);
    check({name, ".valid"}, out_valid, 1);
    check_fields(name, e);
  endtask

  // Present a request with out_ready=1, expect acceptance and the result next edge.
  task automatic issue(input string name, input logic [4:0] op, input logic [3:0] fn,
                       input logic [WIDTH-1:0] opnd, input logic [PC_W-1:0] pc,
                       output res_t e);
    drive(1'b1, op, fn, opnd, pc);
    #1;
    check({name, ".in_ready"}, in_ready, 1);
    model_req(op, fn, opnd, pc, e);
    @(posedge clk); #1;
    check_out(name, e);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 5'd0, 4'd0, '0, '0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [15];
  res_t e, ea, eb;

  initial begin
    vecs[0]  = '{OP_BRANCH, 4'd1, 32'h8000_0000, 16'd1,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_BRANCH, 4'd2, 32'h8000_0000, 16'd1,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_BRANCH, 4'd0, 32'h0000_0000, 16'd6,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_BRANCH, 4'd0, 32'h0000_0001, 16'd6,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_BRANCH, 4'd2, 32'h0000_0001, 16'd8,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_BRANCH, 4'd2, 32'h7FFF_FFFF, 16'd8,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{OP_BRANCH, 4'd1, 32'hFFFF_FFFF, 16'd10, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{OP_BRANCH, 4'd1, 32'h0000_0000, 16'd10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_BRANCH, 4'd2, 32'h0000_0000, 16'd11, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_JUMP,   4'd0, 32'h1234_5678, 16'd2,  1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_JUMP,   4'd1, 32'h0000_0000, 16'd2,  1'b1, 1'b1, 1'b0};
    vecs[11] = '{OP_JUMP,   4'd7, 32'h0000_0000, 16'd2,  1'b0, 1'b0, 1'b1};
    vecs[12] = '{OP_BRANCH, 4'd3, 32'h0000_0000, 16'd2,  1'b0, 1'b0, 1'b1};
    vecs[13] = '{5'b00000,  4'd0, 32'h0000_0000, 16'd2,  1'b0, 1'b0, 1'b1};
    vecs[14] = '{OP_BRANCH, 4'd0, 32'h0000_0000, 16'd2,  1'b1, 1'b0, 1'b0};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 4'd0, '0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid",      out_valid,      0);
    check("reset.taken",      out_taken,      0);
    check("reset.pred",       out_pred,       0);
    check("reset.mispredict", out_mispredict, 0);
    check("reset.link",       out_link,       0);
    check("reset.illegal",    out_illegal,    0);
    check("reset.in_ready",   in_ready,       0);
    reset = 1'b0;
    #1;
    check("post_reset.in_ready", in_ready, 1);

    // Counter training on pc 5: pred 0,1,1 then a not-taken mispredict.
    issue("ctr5_0", OP_BRANCH, 4'd0, 32'd0, 16'd5, e);
    check("ctr5_0.exp", {out_taken, out_pred, out_mispredict}, 3'b101);
    issue("ctr5_1", OP_BRANCH, 4'd0, 32'd0, 16'd5, e);
    check("ctr5_1.pred", out_pred, 1);
    issue("ctr5_2", OP_BRANCH, 4'd0, 32'd0, 16'd5, e);
    check("ctr5_2.pred", out_pred, 1);
    issue("ctr5_nt", OP_BRANCH, 4'd0, 32'd1, 16'd5, e);
    check("ctr5_nt.exp", {out_taken, out_pred, out_mispredict}, 3'b011);
    issue("ctr5_after", OP_BRANCH, 4'd0, 32'd1, 16'd5, e);
    check("ctr5_after.pred", out_pred, 1);

    for (int i = 0; i < 15; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].opnd, vecs[i].pc, e);
      check($sformatf("vec%0d.tbl_taken", i),   out_taken,   vecs[i].taken);
      check($sformatf("vec%0d.tbl_link", i),    out_link,    vecs[i].link);
      check($sformatf("vec%0d.tbl_illegal", i), out_illegal, vecs[i].illegal);
    end

    // Backpressure: hold result A for 4 cycles, then release and accept B same cycle.
    idle_cycle();
    out_ready = 1'b0;
    drive(1'b1, OP_BRANCH, 4'd0, 32'd0, 16'd7);
    #1;
    check("bp_a.in_ready", in_ready, 1);
    model_req(OP_BRANCH, 4'd0, 32'd0, 16'd7, ea);
    @(posedge clk); #1;
    check_out("bp_a", ea);
    drive(1'b1, OP_BRANCH, 4'd0, 32'd5, 16'd7);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_stall.in_ready", in_ready, 0);
      @(posedge clk); #1;
      check_out("bp_hold", ea);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release.in_ready", in_ready, 1);
    model_req(OP_BRANCH, 4'd0, 32'd5, 16'd7, eb);
    @(posedge clk); #1;
    check_out("bp_b", eb);

    // Flush drops the held result and blocks a pc 9 request.
    idle_cycle();
    out_ready = 1'b0;
    issue("fl_a", OP_JUMP, 4'd0, 32'd0, 16'd0, e);
    flush = 1'b1;
    drive(1'b1, OP_BRANCH, 4'd0, 32'd0, 16'd9);
    #1;
    check("fl.in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("fl.valid", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1;
    issue("fl_pc9", OP_BRANCH, 4'd1, 32'd0, 16'd9, e);
    check("fl_pc9.pred", out_pred, 0);

    // Aliasing: pc 3 and pc 19 share a counter.
    issue("alias3", OP_BRANCH, 4'd0, 32'd0, 16'd3, e);
    issue("alias19", OP_BRANCH, 4'd0, 32'd0, 16'd19, e);
    check("alias19.pred", out_pred, 1);

    // Reset together with flush: reset wins and re-initialises the table.
    issue("rf_4a", OP_BRANCH, 4'd0, 32'd0, 16'd4, e);
    issue("rf_4b", OP_BRANCH, 4'd0, 32'd0, 16'd4, e);
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, OP_BRANCH, 4'd0, 32'd0, 16'd4);
    @(posedge clk); #1;
    check("rf.valid", out_valid, 0);
    reset = 1'b0; flush = 1'b0;
    model_reset();
    issue("rf_4c", OP_BRANCH, 4'd1, 32'd0, 16'd4, e);
    check("rf_4c.pred", out_pred, 0);

    // Randomized traffic with handshake tracking.
    idle_cycle();
    begin
      logic ev, v, rdy_o, fl, exp_rdy;
      logic [4:0] op;
      logic [3:0] fn;
      logic [WIDTH-1:0] opnd;
      logic [PC_W-1:0] pc;
      int sel;
      res_t er;
      ev = 1'b0;
      er = '0;
      for (int n = 0; n < 600; n++) begin
        v     = ($urandom_range(0, 3) != 0);
        rdy_o = ($urandom_range(0, 3) != 0);
        fl    = ($urandom_range(0, 15) == 0);
        sel = $urandom_range(0, 9);
        if (sel < 5)      op = OP_BRANCH;
        else if (sel < 8) op = OP_JUMP;
        else              op = 5'($urandom_range(0, 31));
        fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        sel = $urandom_range(0, 5);
        case (sel)
          0: opnd = 32'h0000_0000;
          1: opnd = 32'h0000_0001;
          2: opnd = 32'hFFFF_FFFF;
          3: opnd = 32'h8000_0000;
          4: opnd = 32'h7FFF_FFFF;
          default: opnd = $urandom;
        endcase
        pc = 16'($urandom_range(0, 40));
        drive(v, op, fn, opnd, pc);
        out_ready = rdy_o;
        flush     = fl;
        #1;
        exp_rdy = !fl && (!ev || rdy_o);
        check("rnd.in_ready", in_ready, exp_rdy);
        if (fl) ev = 1'b0;
        else if (v && exp_rdy) begin
          model_req(op, fn, opnd, pc, er);
          ev = 1'b1;
        end else if (rdy_o) ev = 1'b0;
        @(posedge clk); #1;
        check("rnd.valid", out_valid, ev);
        if (ev) check_fields("rnd", er);
      end
    end
    flush = 1'b0;
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
